// File: rtl/obi_cmd_manager.sv
// OBI A/R initiator: turns controller commands into OBI requests and returns responses in issue order.
// Request appears one cycle after command fire; commands stall on pending-ungranted or outstanding limit, R stalls only on a full FIFO.
module obi_cmd_manager #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int RSP_DEPTH       = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  output logic                    obi_req_o,
  input  logic                    obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic                    obi_we_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,
  input  logic                    obi_rvalid_i,
  output logic                    obi_rready_o,
  input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
  input  logic                    obi_err_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_we_o,
  output logic                    busy_o,
  output logic                    spurious_o
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int PTR_W = $clog2(RSP_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BE_W-1:0]       be;
    logic [DATA_WIDTH-1:0] wdata;
  } a_req_t;

  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  we;
  } rsp_t;

  logic             req_q, req_d;
  a_req_t           a_q, a_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic             spur_q, spur_d;
  logic [TAG_W-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic             tag_mem_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  rsp_t             fifo_mem_q [RSP_DEPTH];
  rsp_t             rsp_head;

  logic             fifo_full, fifo_empty;
  logic             cmd_fire, a_gnt, r_acc, r_push, rsp_pop;
  logic [CNT_W:0]   inflight;

  function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(MAX_OUTSTANDING - 1)) ? '0 : p + TAG_W'(1);
  endfunction

  assign fifo_full  = (cnt_q == (PTR_W+1)'(RSP_DEPTH));
  assign fifo_empty = (cnt_q == '0);

  // Counts the held request as in flight; same-cycle retirement is deliberately ignored.
  assign inflight    = {1'b0, out_q} + (CNT_W+1)'(req_q);
  assign cmd_ready_o = (!req_q || obi_gnt_i) && (inflight < (CNT_W+1)'(MAX_OUTSTANDING));
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign a_gnt       = req_q && obi_gnt_i;

  // Nothing outstanding means any rvalid is spurious and is swallowed even when full.
  assign obi_rready_o = !fifo_full || (out_q == '0);
  assign r_acc        = obi_rvalid_i && obi_rready_o;
  assign r_push       = r_acc && (out_q != '0);
  assign rsp_pop      = rsp_valid_o && rsp_ready_i;

  assign obi_req_o   = req_q;
  assign obi_addr_o  = a_q.addr;
  assign obi_we_o    = a_q.we;
  assign obi_be_o    = a_q.be;
  assign obi_wdata_o = a_q.wdata;

  assign rsp_head    = fifo_mem_q[rd_ptr_q];
  assign rsp_valid_o = !fifo_empty;
  assign rsp_rdata_o = rsp_head.rdata;
  assign rsp_err_o   = rsp_head.err;
  assign rsp_we_o    = rsp_head.we;
  assign busy_o      = req_q || (out_q != '0) || !fifo_empty;
  assign spurious_o  = spur_q;

  always_comb begin
    req_d = req_q;
    a_d   = a_q;
    if (cmd_fire) begin
      req_d = 1'b1;
      a_d   = '{addr: cmd_addr_i, we: cmd_we_i, be: cmd_be_i, wdata: cmd_wdata_i};
    end else if (a_gnt) begin
      req_d = 1'b0;
    end

    out_d = out_q;
    if (a_gnt && !r_push) out_d = out_q + CNT_W'(1);
    else if (!a_gnt && r_push) out_d = out_q - CNT_W'(1);

    spur_d   = spur_q || (obi_rvalid_i && (out_q == '0));
    tag_wr_d = a_gnt ? tag_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d = r_push ? tag_inc(tag_rd_q) : tag_rd_q;

    wr_ptr_d = r_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rsp_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (r_push && !rsp_pop) cnt_d = cnt_q + (PTR_W+1)'(1);
    else if (!r_push && rsp_pop) cnt_d = cnt_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      req_q    <= 1'b0;
      a_q      <= '0;
      out_q    <= '0;
      spur_q   <= 1'b0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      req_q    <= req_d;
      a_q      <= a_d;
      out_q    <= out_d;
      spur_q   <= spur_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage arrays need no reset: pointers and counts define which entries are live.
  always_ff @(posedge clk_i) begin
    if (a_gnt) tag_mem_q[tag_wr_q] <= a_q.we;
    if (r_push) fifo_mem_q[wr_ptr_q] <= '{err: obi_err_i, rdata: obi_rdata_i, we: tag_mem_q[tag_rd_q]};
  end
endmodule
